// File: rtl/timer_cfg_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : timer_cfg_seq
//  Purpose  : APB master sequencer that turns START / STOP / READ_CNT
//             commands into ordered APB transfers towards the timer
//             peripheral (TCR 0x0, TCNT 0x4, PSC 0x8, ARR 0xC).
//  Ports    : PCLK, PRESETn (async active-low)
//             req_valid/req_ready/req_op/req_psc/req_arr   command port
//             rsp_valid/rsp_cnt/rsp_err, busy              response/status
//             PADDR/PWDATA/PWRITE/PSEL/PENABLE/PRDATA/PREADY  APB master
//  Options  : TIMER_CFG_TIMEOUT_EN enables the PREADY timeout abort
//             (TIMEOUT_CYC ACCESS cycles); otherwise ACCESS waits forever
//             and rsp_err is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module timer_cfg_seq #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_psc,
  input  logic [31:0] req_arr,
  output logic        rsp_valid,
  output logic [31:0] rsp_cnt,
  output logic        rsp_err,
  output logic        busy,
  output logic [3:0]  PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  localparam logic [3:0] ADDR_TCR  = 4'h0;
  localparam logic [3:0] ADDR_TCNT = 4'h4;
  localparam logic [3:0] ADDR_PSC  = 4'h8;
  localparam logic [3:0] ADDR_ARR  = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // A zero or negative timeout would make the abort compare meaningless.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("timer_cfg_seq: TIMEOUT_CYC must be >= 1");
  end

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] psc_q, psc_d;
  logic [31:0] arr_q, arr_d;
  logic [31:0] rsp_cnt_q, rsp_cnt_d;

`ifdef TIMER_CFG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rsp_err_q, rsp_err_d;
  logic             tmo_hit;
`endif

  // Current transfer decoded from the latched op and step index.
  logic [3:0]  xfer_addr;
  logic [31:0] xfer_data;
  logic        xfer_write;
  logic        last_step;
  logic        apb_active;

  always_comb begin
    xfer_addr  = ADDR_TCR;
    xfer_data  = 32'd0;
    xfer_write = 1'b1;
    case (op_q)
      OP_START: begin
        case (step_q)
          2'd0: begin xfer_addr = ADDR_TCR; xfer_data = 32'h2; end
          2'd1: begin xfer_addr = ADDR_PSC; xfer_data = psc_q; end
          2'd2: begin xfer_addr = ADDR_ARR; xfer_data = arr_q; end
          default: begin xfer_addr = ADDR_TCR; xfer_data = 32'h1; end
        endcase
      end
      OP_STOP: begin
        xfer_addr = ADDR_TCR;
        xfer_data = 32'h0;
      end
      OP_READ: begin
        xfer_addr  = ADDR_TCNT;
        xfer_write = 1'b0;
      end
      default: begin
        xfer_write = 1'b0;
      end
    endcase
  end

  assign last_step  = (op_q == OP_START) ? (step_q == 2'd3) : 1'b1;
  assign apb_active = (state_q == S_SETUP) || (state_q == S_ACCESS);

  // Address/data are forced to zero outside a transfer so the bus is quiet
  // in IDLE and DONE.
  assign PSEL      = apb_active;
  assign PENABLE   = (state_q == S_ACCESS);
  assign PADDR     = apb_active ? xfer_addr  : 4'h0;
  assign PWDATA    = (apb_active && xfer_write) ? xfer_data : 32'd0;
  assign PWRITE    = apb_active && xfer_write;
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_cnt   = rsp_cnt_q;

`ifdef TIMER_CFG_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    op_d      = op_q;
    psc_d     = psc_q;
    arr_d     = arr_q;
    rsp_cnt_d = rsp_cnt_q;
`ifdef TIMER_CFG_TIMEOUT_EN
    tmo_d     = tmo_q;
    rsp_err_d = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          // The slave divider compares against psc-1, so 0 is promoted to 1.
          psc_d  = (req_psc == 32'd0) ? 32'd1 : req_psc;
          arr_d  = req_arr;
          step_d = 2'd0;
          if (req_op == OP_NOP) begin
            state_d   = S_DONE;
            rsp_cnt_d = 32'd0;
`ifdef TIMER_CFG_TIMEOUT_EN
            rsp_err_d = 1'b0;
`endif
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef TIMER_CFG_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_ACCESS: begin
`ifdef TIMER_CFG_TIMEOUT_EN
        tmo_d = tmo_q + TMO_W'(1);
`endif
        if (PREADY) begin
          if (last_step) begin
            state_d   = S_DONE;
            // Only a read returns data; the response value is updated on
            // entry to DONE so it stays stable between responses.
            rsp_cnt_d = (op_q == OP_READ) ? PRDATA : 32'd0;
`ifdef TIMER_CFG_TIMEOUT_EN
            rsp_err_d = 1'b0;
`endif
          end else begin
            step_d  = step_q + 2'd1;
            state_d = S_SETUP;
          end
        end
`ifdef TIMER_CFG_TIMEOUT_EN
        else if (tmo_hit) begin
          // Abort: skip remaining steps and report the error.
          state_d   = S_DONE;
          rsp_cnt_d = 32'd0;
          rsp_err_d = 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      step_q    <= 2'd0;
      op_q      <= 2'd0;
      psc_q     <= 32'd0;
      arr_q     <= 32'd0;
      rsp_cnt_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      op_q      <= op_d;
      psc_q     <= psc_d;
      arr_q     <= arr_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

`ifdef TIMER_CFG_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_timer_cfg_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_timer_cfg_seq
//  Purpose  : Self-checking bench for timer_cfg_seq with an APB slave model
//             and a transfer-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_cfg_seq;

  localparam int TIMEOUT_CYC = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_psc = 32'd0;
  logic [31:0] req_arr = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_cnt;
  logic        rsp_err;
  logic        busy;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA = 32'd0;
  logic        PREADY = 1'b0;

  timer_cfg_seq #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_psc(req_psc), .req_arr(req_arr),
    .rsp_valid(rsp_valid), .rsp_cnt(rsp_cnt), .rsp_err(rsp_err), .busy(busy),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        wr;
  } xfer_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    wait_n   = 0;
  int    acc_seen = 0;
  int    prot_err = 0;
  logic [3:0]  setup_addr = 4'h0;
  logic [31:0] setup_data = 32'd0;
  xfer_t mon_q[$];

  always @(posedge PCLK) cyc++;

  // APB slave: PREADY rises after wait_n extra ACCESS cycles; completed
  // transfers are logged together with the read data it returned.
  always @(negedge PCLK) begin
    if (PENABLE && !PSEL) prot_err++;
    if (PSEL && PENABLE) begin
      if (PADDR !== setup_addr || PWDATA !== setup_data) prot_err++;
      PREADY = (acc_seen >= wait_n);
      PRDATA = $urandom;
      acc_seen++;
      if (PREADY) mon_q.push_back(xfer_t'{PADDR, PWRITE ? PWDATA : PRDATA, PWRITE});
    end else begin
      PREADY   = 1'b0;
      acc_seen = 0;
      if (PSEL) begin
        setup_addr = PADDR;
        setup_data = PWDATA;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
  endtask

  // Issue one command and check it against the transfer-list model.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] psc,
                         input logic [31:0] arr, input int wn, output int lat);
    xfer_t       exp_q[$];
    bit          abort;
    bit          got;
    int          exp_lat;
    int          c0;
    logic [31:0] exp_cnt;
    exp_q = {};
    case (op)
      2'd0: begin
        exp_q.push_back(xfer_t'{4'h0, 32'h2, 1'b1});
        exp_q.push_back(xfer_t'{4'h8, (psc == 32'd0) ? 32'd1 : psc, 1'b1});
        exp_q.push_back(xfer_t'{4'hC, arr, 1'b1});
        exp_q.push_back(xfer_t'{4'h0, 32'h1, 1'b1});
      end
      2'd1: exp_q.push_back(xfer_t'{4'h0, 32'h0, 1'b1});
      2'd2: exp_q.push_back(xfer_t'{4'h4, 32'h0, 1'b0});
      default: ;
    endcase
    abort = 1'b0;
`ifdef TIMER_CFG_TIMEOUT_EN
    abort = (op != 2'd3) && (wn + 1 > TIMEOUT_CYC);
`endif
    if (op == 2'd3)  exp_lat = 1;
    else if (abort)  exp_lat = TIMEOUT_CYC + 2;
    else             exp_lat = exp_q.size() * (wn + 2) + 1;
    if (abort) exp_q = {};

    wait_n = wn;
    mon_q  = {};
    @(negedge PCLK);
    req_valid = 1'b1; req_op = op; req_psc = psc; req_arr = arr;
    c0 = cyc;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge PCLK);
    // Scramble request fields: the DUT must use its latched copy.
    req_valid = 1'b0; req_op = 2'($urandom); req_psc = $urandom; req_arr = $urandom;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    wait_rsp(got);
    chk("rsp_arrived", 32'(got), 32'd1);
    lat = got ? (cyc - c0) : -1;
    if (got) begin
      chk("latency", lat, exp_lat);
      chk("rsp_err", 32'(rsp_err), 32'(abort));
      chk("xfer_count", mon_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
        chk("xfer_addr", 32'(mon_q[i].addr), 32'(exp_q[i].addr));
        chk("xfer_write", 32'(mon_q[i].wr), 32'(exp_q[i].wr));
        if (exp_q[i].wr) chk("xfer_wdata", mon_q[i].data, exp_q[i].data);
      end
      exp_cnt = (op == 2'd2 && !abort && mon_q.size() > 0) ? mon_q[0].data : 32'd0;
      chk("rsp_cnt", rsp_cnt, exp_cnt);
      @(negedge PCLK);
      chk("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
      chk("req_ready_after", 32'(req_ready), 32'd1);
      chk("rsp_cnt_held", rsp_cnt, exp_cnt);
    end
    chk("apb_protocol", prot_err, 0);
  endtask

  int          lat;
  int          c0;
  int          r0;
  bit          got;
  int          seen;
  logic [1:0]  rop;
  logic [31:0] rpsc;

  initial begin
    // Reset state
    repeat (3) @(negedge PCLK);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_cnt", rsp_cnt, 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // START against a registered-PREADY slave: done at T+13
    run_cmd(2'd0, 32'd10, 32'd5, 1, lat);
    chk("start_lat_13", lat, 13);
    // STOP and READ_CNT: done at T+4
    run_cmd(2'd1, 32'd0, 32'd0, 1, lat);
    chk("stop_lat_4", lat, 4);
    run_cmd(2'd0, 32'd1, 32'd100, 0, lat);
    run_cmd(2'd2, 32'd0, 32'd0, 1, lat);
    chk("read_lat_4", lat, 4);
    // psc==0 promoted to 1
    run_cmd(2'd0, 32'd0, 32'd7, 2, lat);
    // NOP completes in the cycle after accept
    run_cmd(2'd3, 32'd5, 32'd5, 0, lat);
    chk("nop_lat_1", lat, 1);
    // PREADY held low for 20 ACCESS cycles
    run_cmd(2'd2, 32'd0, 32'd0, 20, lat);
    run_cmd(2'd0, 32'd3, 32'd4, 19, lat);

    // Randomized commands
    for (int k = 0; k < 10; k++) begin
      rop  = 2'($urandom_range(0, 3));
      rpsc = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_cmd(rop, rpsc, $urandom, $urandom_range(0, 3), lat);
    end

    // Busy/hold: req_valid stays high with STOP while START runs
    wait_n = 1;
    mon_q  = {};
    @(negedge PCLK);
    req_valid = 1'b1; req_op = 2'd0; req_psc = 32'd7; req_arr = 32'd9;
    c0 = cyc;
    @(negedge PCLK);
    req_op = 2'd1;
    chk("hold_busy", 32'(busy), 32'd1);
    wait_rsp(got);
    chk("hold_start_rsp", 32'(got), 32'd1);
    r0 = cyc;
    chk("hold_start_lat", r0 - c0, 13);
    chk("hold_start_xfers", mon_q.size(), 4);
    @(negedge PCLK);
    chk("hold_ready_idle", 32'(req_ready), 32'd1);
    @(negedge PCLK);
    req_valid = 1'b0;
    chk("hold_stop_busy", 32'(busy), 32'd1);
    wait_rsp(got);
    chk("hold_stop_rsp", 32'(got), 32'd1);
    chk("hold_stop_lat", cyc - r0, 5);
    chk("hold_total_xfers", mon_q.size(), 5);
    chk("hold_stop_addr", (mon_q.size() > 4) ? 32'(mon_q[4].addr) : 32'hFFFF, 32'h0);
    chk("hold_stop_data", (mon_q.size() > 4) ? mon_q[4].data : 32'hFFFF, 32'h0);
    @(negedge PCLK);

    // Reset pulse during ACCESS of the second START transfer
    wait_n = 3;
    mon_q  = {};
    @(negedge PCLK);
    req_valid = 1'b1; req_op = 2'd0; req_psc = 32'd2; req_arr = 32'd3;
    @(negedge PCLK);
    req_valid = 1'b0;
    repeat (6) @(negedge PCLK);
    chk("mid_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
    chk("mid_step2", 32'(PADDR), 32'h8);
    #1 PRESETn = 1'b0;
    #1;
    chk("mid_psel_drop", 32'(PSEL), 32'd0);
    chk("mid_penable_drop", 32'(PENABLE), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (rsp_valid) seen++;
    end
    chk("mid_no_rsp", seen, 0);
    chk("mid_xfers", mon_q.size(), 1);
    chk("mid_idle", 32'(req_ready), 32'd1);

    // Normal operation after the reset pulse
    run_cmd(2'd2, 32'd0, 32'd0, 1, lat);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
